kb_matrix_scanner: RTL



---
 rtl/kb_matrix_scanner_if.sv | 20 ++
 rtl/kb_matrix_scanner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/kb_matrix_scanner_if.sv
// Keypad matrix and key-event signals between the scanner (master) and the
// keypad / key consumer side (slave).
interface kb_matrix_scanner_if;
    logic [3:0] keyboard_col;
    logic [3:0] keyboard_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic       key_multi;

    modport master (
        output keyboard_col, key_code, key_valid, key_pressed, key_multi,
        input  keyboard_row
    );

    modport slave (
        input  keyboard_col, key_code, key_valid, key_pressed, key_multi,
        output keyboard_row
    );
endinterface

// File: rtl/kb_matrix_scanner.sv
// 4x4 keypad scanner: column drive, 16-key snapshot debounce, one-shot key events.
// Optional auto-repeat while a single key is held: define KB_AUTO_REPEAT_EN.
//
// state   | meaning
// S_IDLE  | debounced snapshot empty, ready to accept a new key
// S_HELD  | exactly one key accepted and still held
// S_MULTI | several keys, or a changed key, seen; waiting for full release
module kb_matrix_scanner #(
    parameter int COL_PERIOD     = 2500,
    parameter int DEBOUNCE_SCANS = 2,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    kb_matrix_scanner_if.master kb
);

    localparam int DIV_W = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_MULTI} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic [3:0]       col_drv_q;
    logic [3:0]       row_s1_q;
    logic [3:0]       row_s_q;
    logic [15:0]      snap_q;
    logic [15:0]      prev_q;
    logic [15:0]      deb_q;
    logic [3:0]       stable_cnt_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_pressed_q;
    logic             key_multi_q;

`ifdef KB_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    logic [RPT_W-1:0] rep_q;
`endif

    logic        tc;
    logic        sc;
    logic [1:0]  col_nx;
    logic [15:0] snap_d;
    logic [3:0]  stable_cnt_d;
    logic [15:0] deb_d;
    logic        deb_nz;
    logic        deb_many;
    logic        deb_one;
    logic [3:0]  deb_idx;

    always_comb begin
        tc     = (div_q == DIV_W'(COL_PERIOD - 1));
        sc     = tc && (col_q == 2'd3);
        col_nx = col_q + 2'd1;

        snap_d = snap_q;
        if (tc) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_q}] = row_s_q[2'(r)];
            end
        end

        if (snap_d == prev_q) begin
            stable_cnt_d = (stable_cnt_q == 4'(DEBOUNCE_SCANS)) ? stable_cnt_q
                                                                : stable_cnt_q + 4'd1;
        end else begin
            stable_cnt_d = 4'd1;
        end

        deb_d    = (stable_cnt_d == 4'(DEBOUNCE_SCANS)) ? snap_d : deb_q;
        deb_nz   = (deb_d != 16'h0000);
        // Clearing the lowest set bit leaves something only if 2+ bits were set.
        deb_many = ((deb_d & (deb_d - 16'd1)) != 16'h0000);
        deb_one  = deb_nz && !deb_many;

        deb_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (deb_d[4'(i)]) deb_idx = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            col_q         <= 2'd0;
            col_drv_q     <= 4'b1110;
            row_s1_q      <= 4'h0;
            row_s_q       <= 4'h0;
            snap_q        <= 16'h0000;
            prev_q        <= 16'h0000;
            deb_q         <= 16'h0000;
            stable_cnt_q  <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            key_multi_q   <= 1'b0;
`ifdef KB_AUTO_REPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            // Inverted on entry so a cleared synchroniser reads as "no key".
            row_s1_q    <= ~kb.keyboard_row;
            row_s_q     <= row_s1_q;
            key_valid_q <= 1'b0;

            if (tc) begin
                div_q     <= '0;
                col_q     <= col_nx;
                col_drv_q <= ~(4'b0001 << col_nx);
                snap_q    <= snap_d;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (sc) begin
                prev_q        <= snap_d;
                stable_cnt_q  <= stable_cnt_d;
                deb_q         <= deb_d;
                key_pressed_q <= deb_nz;
                key_multi_q   <= deb_many;

                case (state_q)
                    S_IDLE: begin
                        if (deb_one) begin
                            state_q     <= S_HELD;
                            key_code_q  <= deb_idx;
                            key_valid_q <= 1'b1;
`ifdef KB_AUTO_REPEAT_EN
                            rep_q       <= RPT_W'(REPEAT_DELAY);
`endif
                        end else if (deb_many) begin
                            state_q <= S_MULTI;
                        end
                    end
                    S_HELD: begin
                        if (!deb_nz) begin
                            state_q <= S_IDLE;
`ifdef KB_AUTO_REPEAT_EN
                            rep_q   <= '0;
`endif
                        end else if (deb_many || (deb_idx != key_code_q)) begin
                            // A different key must wait for full release like a chord.
                            state_q <= S_MULTI;
`ifdef KB_AUTO_REPEAT_EN
                            rep_q   <= '0;
`endif
                        end else begin
`ifdef KB_AUTO_REPEAT_EN
                            if (rep_q == RPT_W'(1)) begin
                                key_valid_q <= 1'b1;
                                rep_q       <= RPT_W'(REPEAT_RATE);
                            end else begin
                                rep_q <= rep_q - RPT_W'(1);
                            end
`endif
                        end
                    end
                    S_MULTI: begin
                        if (!deb_nz) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign kb.keyboard_col = col_drv_q;
    assign kb.key_code     = key_code_q;
    assign kb.key_valid    = key_valid_q;
    assign kb.key_pressed  = key_pressed_q;
    assign kb.key_multi    = key_multi_q;

endmodule
